// File: rtl/matrix3_window_scheduler.sv
// Write/read sequencer for a 3-row frame buffer feeding a 3x3 window stage.
// Optional MATRIX3_WINDOW_SCHEDULER_STATS_EN adds window and frame counters.
module matrix3_window_scheduler #(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS    = 480,
  parameter int P_READ_LATENCY  = 1,
  localparam int P_COLUMN_BITS  = $clog2(P_FRAME_COLUMNS),
  localparam int P_ROW_BITS     = $clog2(P_FRAME_ROWS)
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET,
  input  logic                     I_ENABLE,
  input  logic                     I_VSYNC,
  input  logic                     I_PIXEL_STROBE,
  output logic                     O_WR_EN,
  output logic [P_COLUMN_BITS-1:0] O_WR_COL,
  output logic [1:0]               O_WR_BANK,
  output logic                     O_RD_EN,
  output logic [P_COLUMN_BITS-1:0] O_RD_COL,
  output logic [P_ROW_BITS-1:0]    O_RD_ROW,
  output logic                     O_WINDOW_VALID,
  output logic                     O_FRAME_DONE,
  output logic                     O_BUSY
`ifdef MATRIX3_WINDOW_SCHEDULER_STATS_EN
  ,
  output logic [31:0]              O_WINDOW_COUNT,
  output logic [15:0]              O_FRAME_COUNT
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STREAM, ST_DRAIN} state_t;

  localparam logic [P_COLUMN_BITS-1:0] LAST_COL = P_COLUMN_BITS'(P_FRAME_COLUMNS - 1);
  localparam logic [P_ROW_BITS-1:0]    LAST_ROW = P_ROW_BITS'(P_FRAME_ROWS - 1);

  state_t                    state_q, state_d;
  logic [P_COLUMN_BITS-1:0]  col_q, col_d;
  logic [P_ROW_BITS-1:0]     row_q, row_d;
  logic [1:0]                bank_q, bank_d;
  logic                      wr_en_q, wr_en_d;
  logic [P_COLUMN_BITS-1:0]  wr_col_q, wr_col_d;
  logic [1:0]                wr_bank_q, wr_bank_d;
  logic                      rd_en_q, rd_en_d;
  logic [P_COLUMN_BITS-1:0]  rd_col_q, rd_col_d;
  logic [P_ROW_BITS-1:0]     rd_row_q, rd_row_d;
  logic [P_READ_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
  logic                      window_valid_q, window_valid_d;
  logic                      frame_done_q, frame_done_d;
  logic                      busy_q, busy_d;
  logic [31:0]               window_count_q, window_count_d;
  logic [15:0]               frame_count_q, frame_count_d;

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    bank_d         = bank_q;
    wr_en_d        = 1'b0;
    wr_col_d       = wr_col_q;
    wr_bank_d      = wr_bank_q;
    rd_en_d        = 1'b0;
    rd_col_d       = rd_col_q;
    rd_row_d       = rd_row_q;
    rd_pipe_d      = rd_pipe_q;
    window_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    window_count_d = window_count_q;
    frame_count_d  = frame_count_q;

    if (I_ENABLE) begin
      if (I_VSYNC) begin
        // Frame start, or abort of a frame in flight: nothing pending survives.
        state_d        = ST_FILL;
        col_d          = '0;
        row_d          = '0;
        bank_d         = '0;
        rd_pipe_d      = '0;
        window_count_d = '0;
      end else begin
        window_valid_d = rd_pipe_q[P_READ_LATENCY-1];
        case (state_q)
          ST_FILL, ST_STREAM: begin
            if (I_PIXEL_STROBE) begin
              wr_en_d   = 1'b1;
              wr_col_d  = col_q;
              wr_bank_d = bank_q;
              // Centre of a complete neighbourhood sits one row and one column back.
              if (row_q >= P_ROW_BITS'(2) && col_q >= P_COLUMN_BITS'(2)) begin
                rd_en_d  = 1'b1;
                rd_col_d = col_q - 1'b1;
                rd_row_d = row_q - 1'b1;
              end
              if (col_q == LAST_COL) begin
                col_d  = '0;
                row_d  = row_q + 1'b1;
                bank_d = (bank_q == 2'd2) ? 2'd0 : bank_q + 2'd1;
                if (state_q == ST_FILL && row_q == P_ROW_BITS'(1)) begin
                  state_d = ST_STREAM;
                end else if (state_q == ST_STREAM && row_q == LAST_ROW) begin
                  state_d = ST_DRAIN;
                end
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (rd_pipe_q == '0) begin
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              state_d       = ST_IDLE;
            end
          end
          default: ;
        endcase
        rd_pipe_d = (rd_pipe_q << 1) | P_READ_LATENCY'(rd_en_d);
        if (window_valid_d) begin
          window_count_d = window_count_q + 32'd1;
        end
      end
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_CLK or negedge I_RESET) begin
    if (!I_RESET) begin
      state_q        <= ST_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      bank_q         <= '0;
      wr_en_q        <= 1'b0;
      wr_col_q       <= '0;
      wr_bank_q      <= '0;
      rd_en_q        <= 1'b0;
      rd_col_q       <= '0;
      rd_row_q       <= '0;
      rd_pipe_q      <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      window_count_q <= '0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      bank_q         <= bank_d;
      wr_en_q        <= wr_en_d;
      wr_col_q       <= wr_col_d;
      wr_bank_q      <= wr_bank_d;
      rd_en_q        <= rd_en_d;
      rd_col_q       <= rd_col_d;
      rd_row_q       <= rd_row_d;
      rd_pipe_q      <= rd_pipe_d;
      window_valid_q <= window_valid_d;
      frame_done_q   <= frame_done_d;
      busy_q         <= busy_d;
      window_count_q <= window_count_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign O_WR_EN        = wr_en_q;
  assign O_WR_COL       = wr_col_q;
  assign O_WR_BANK      = wr_bank_q;
  assign O_RD_EN        = rd_en_q;
  assign O_RD_COL       = rd_col_q;
  assign O_RD_ROW       = rd_row_q;
  assign O_WINDOW_VALID = window_valid_q;
  assign O_FRAME_DONE   = frame_done_q;
  assign O_BUSY         = busy_q;

`ifdef MATRIX3_WINDOW_SCHEDULER_STATS_EN
  assign O_WINDOW_COUNT = window_count_q;
  assign O_FRAME_COUNT  = frame_count_q;
`else
  logic unused_stats;
  assign unused_stats = ^{window_count_q, frame_count_q};
`endif

endmodule

// File: tb/tb_matrix3_window_scheduler.sv
// Bench for matrix3_window_scheduler (4x4 frame, read latency 2) against a pixel-index
// reference model; stats checks apply when MATRIX3_WINDOW_SCHEDULER_STATS_EN is defined.
module tb_matrix3_window_scheduler;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_en = 1'b1, i_vsync = 1'b0, i_pix = 1'b0;
  logic o_wr_en, o_rd_en, o_valid, o_done, o_busy;
  logic [1:0] o_wr_col, o_wr_bank, o_rd_col, o_rd_row;
`ifdef MATRIX3_WINDOW_SCHEDULER_STATS_EN
  logic [31:0] o_wcount;
  logic [15:0] o_fcount;
`endif

  matrix3_window_scheduler #(
    .P_FRAME_COLUMNS(COLS), .P_FRAME_ROWS(ROWS), .P_READ_LATENCY(LAT)
  ) dut (
    .I_CLK(clk), .I_RESET(rst_n), .I_ENABLE(i_en), .I_VSYNC(i_vsync),
    .I_PIXEL_STROBE(i_pix), .O_WR_EN(o_wr_en), .O_WR_COL(o_wr_col),
    .O_WR_BANK(o_wr_bank), .O_RD_EN(o_rd_en), .O_RD_COL(o_rd_col),
    .O_RD_ROW(o_rd_row), .O_WINDOW_VALID(o_valid), .O_FRAME_DONE(o_done),
    .O_BUSY(o_busy)
`ifdef MATRIX3_WINDOW_SCHEDULER_STATS_EN
    , .O_WINDOW_COUNT(o_wcount), .O_FRAME_COUNT(o_fcount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: frame progress as a count of written pixels plus a list of due valid ticks.
  int mode;        // 0 idle, 1 accepting pixels, 2 draining
  int k;           // pixels written this frame
  int ecount;      // enabled clock edges seen
  int done_due;
  int due[$];
  int m_wcount, m_fcount;
  bit m_last_rd;
  int obs_valids, obs_dones;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode = 0; k = 0; done_due = -1; due.delete();
    m_wcount = 0; m_fcount = 0; m_last_rd = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, o_wr_en, 0);
    chk({tag, "_rd_en"}, o_rd_en, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_wr_col"}, o_wr_col, 0);
    chk({tag, "_wr_bank"}, o_wr_bank, 0);
    chk({tag, "_rd_col"}, o_rd_col, 0);
    chk({tag, "_rd_row"}, o_rd_row, 0);
`ifdef MATRIX3_WINDOW_SCHEDULER_STATS_EN
    chk({tag, "_wcount"}, o_wcount, 0);
    chk({tag, "_fcount"}, o_fcount, 0);
`endif
  endtask

  task automatic tick(input bit vs, input bit st, input bit en);
    bit e_wr, e_rd, e_vl, e_dn;
    int col, row, e_wcol, e_bank, e_rcol, e_rrow;
    e_wr = 0; e_rd = 0; e_vl = 0; e_dn = 0;
    e_wcol = 0; e_bank = 0; e_rcol = 0; e_rrow = 0;
    i_vsync = vs; i_pix = st; i_en = en;
    @(posedge clk); #1;
    if (en) begin
      ecount++;
      if (vs) begin
        mode = 1; k = 0; due.delete(); done_due = -1; m_wcount = 0;
      end else begin
        if (due.size() > 0 && due[0] == ecount) begin
          e_vl = 1;
          void'(due.pop_front());
        end
        if (mode == 1 && st) begin
          col = k % COLS; row = k / COLS;
          e_wr = 1; e_wcol = col; e_bank = row % 3;
          if (row >= 2 && col >= 2) begin
            e_rd = 1; e_rcol = col - 1; e_rrow = row - 1;
            due.push_back(ecount + LAT);
          end
          k++;
          if (k == COLS * ROWS) begin
            mode = 2; done_due = ecount + LAT + 1;
          end
        end else if (mode == 2 && ecount == done_due) begin
          e_dn = 1; mode = 0; m_fcount++;
        end
        if (e_vl) m_wcount++;
      end
    end
    m_last_rd = e_rd;
    obs_valids += int'(o_valid);
    obs_dones  += int'(o_done);
    $display("t=%0t vs=%0b st=%0b en=%0b | wr=%0b col=%0d bank=%0d rd=%0b (%0d,%0d) vld=%0b done=%0b busy=%0b",
             $time, vs, st, en, o_wr_en, o_wr_col, o_wr_bank, o_rd_en, o_rd_row, o_rd_col,
             o_valid, o_done, o_busy);
    chk("wr_en", o_wr_en, e_wr);
    chk("rd_en", o_rd_en, e_rd);
    chk("window_valid", o_valid, e_vl);
    chk("frame_done", o_done, e_dn);
    chk("busy", o_busy, mode != 0);
    if (e_wr) begin
      chk("wr_col", o_wr_col, e_wcol);
      chk("wr_bank", o_wr_bank, e_bank);
    end
    if (e_rd) begin
      chk("rd_col", o_rd_col, e_rcol);
      chk("rd_row", o_rd_row, e_rrow);
    end
`ifdef MATRIX3_WINDOW_SCHEDULER_STATS_EN
    chk("window_count", o_wcount, m_wcount);
    chk("frame_count", o_fcount, m_fcount);
`endif
    i_vsync = 0; i_pix = 0; i_en = 1;
  endtask

  task automatic apply_reset();
    rst_n = 0; #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  initial begin
    ecount = 0; obs_valids = 0; obs_dones = 0;
    model_reset();
    #2;
    chk_zero("por");
    apply_reset();

    // 1: full frame of back-to-back strobes
    tick(1, 0, 1);
    for (int i = 0; i < COLS * ROWS; i++) tick(0, 1, 1);
    obs_valids = 0; obs_dones = 0;
    for (int i = 0; i < 8; i++) tick(0, 0, 1);
    chk("t1_windows_tail", obs_valids, 2);
    chk("t1_dones", obs_dones, 1);
    chk("t1_busy_after", o_busy, 0);

    // 2: strobes while idle
    for (int i = 0; i < 6; i++) tick(0, 1, 1);
    chk("t2_busy", o_busy, 0);

    // 3: abort after 10 pixels, restart with gapped strobes
    tick(1, 0, 1);
    for (int i = 0; i < 10; i++) tick(0, 1, 1);
    tick(1, 1, 1);
    obs_valids = 0; obs_dones = 0;
    for (int n = 0; n < COLS * ROWS;) begin
      bit s;
      s = ($urandom_range(0, 3) != 0);
      tick(0, s, 1);
      if (s) n++;
    end
    for (int i = 0; i < 8; i++) tick(0, 0, 1);
    chk("t3_windows", obs_valids, 4);
    chk("t3_dones", obs_dones, 1);

    // 4: enable low for 5 cycles mid-row with strobes driven
    tick(1, 0, 1);
    for (int i = 0; i < 6; i++) tick(0, 1, 1);
    for (int i = 0; i < 5; i++) tick(0, 1, 0);
    obs_valids = 0;
    for (int i = 0; i < COLS * ROWS - 6; i++) tick(0, 1, 1);
    for (int i = 0; i < 8; i++) tick(0, 0, 1);
    chk("t4_windows", obs_valids, 4);

    // 5: reset one cycle after a read
    tick(1, 0, 1);
    for (int i = 0; i < 40 && !m_last_rd; i++) tick(0, 1, 1);
    chk("t5_saw_rd", o_rd_en, 1);
    tick(0, 0, 1);
    rst_n = 0; #1;
    chk_zero("t5_rst0");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk_zero("t5_rst");
    end
    rst_n = 1;
    model_reset();

    // Randomized frames with enable drops and occasional aborts
    for (int f = 0; f < 6; f++) begin
      tick(1, 0, 1);
      for (int i = 0; i < 200 && mode != 0; i++) begin
        if ($urandom_range(0, 60) == 0) tick(1, 0, 1);
        else tick(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
      end
      for (int i = 0; i < 3; i++) tick(0, $urandom_range(0, 1), 1);
    end

    // 6: two full frames from reset for the statistics counters
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      tick(1, 0, 1);
      for (int i = 0; i < COLS * ROWS; i++) tick(0, 1, 1);
      for (int i = 0; i < 6; i++) tick(0, 0, 1);
    end
    chk("t6_busy", o_busy, 0);
`ifdef MATRIX3_WINDOW_SCHEDULER_STATS_EN
    chk("t6_frame_count", o_fcount, 2);
    chk("t6_window_count", o_wcount, 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
